// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory request arbiter.
//   NumReq      : number of requesters (4)
//   Enc*        : 4-bit state encodings, IDLE = 0
//   state_e     : arbiter FSM state type built on those encodings
//   onehot4()   : requester index -> one-hot vector
package mem_arb_pkg;

   localparam int unsigned NumReq = 4;

   localparam logic [3:0] EncIdle  = 4'd0;
   localparam logic [3:0] EncGrant = 4'd1;
   localparam logic [3:0] EncRecov = 4'd2;
   localparam logic [3:0] EncPsave = 4'd3;
   localparam logic [3:0] EncPoff  = 4'd4;
   localparam logic [3:0] EncPrest = 4'd5;

   typedef enum logic [3:0] {
      StIdle  = EncIdle,
      StGrant = EncGrant,
      StRecov = EncRecov,
      StPsave = EncPsave,
      StPoff  = EncPoff,
      StPrest = EncPrest
   } state_e;

   function automatic logic [NumReq-1:0] onehot4(input logic [1:0] idx);
      logic [NumReq-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mem_req_arb_if.sv
// Handshake bundle between the requesters/memory controller and the arbiter.
//   slave  : arbiter side (consumes req/do_acpt/power requests, drives grants and strobes)
//   master : environment side (requesters + controller)
interface mem_req_arb_if;
   import mem_arb_pkg::*;

   logic [NumReq-1:0] req;
   logic [NumReq-1:0] gnt;
   logic [NumReq-1:0] ack;
   logic              do_rdy;
   logic [1:0]        memsel;
   logic              do_acpt;
   logic              busy;
   logic              err;
   logic              pwr_dn_req;
   logic              pwr_up_req;
   logic              mc_pwr;
   logic              mc_save;
   logic              mc_restore;
   logic              mc_pwr_ack;

   modport slave (
      input  req, do_acpt, pwr_dn_req, pwr_up_req, mc_pwr_ack,
      output gnt, ack, do_rdy, memsel, busy, err, mc_pwr, mc_save, mc_restore
   );

   modport master (
      output req, do_acpt, pwr_dn_req, pwr_up_req, mc_pwr_ack,
      input  gnt, ack, do_rdy, memsel, busy, err, mc_pwr, mc_save, mc_restore
   );

endinterface

// File: rtl/mem_req_arb_rr_pick4.sv
// Combinational round-robin picker for four requesters.
//   req   : request vector
//   last  : index of the previous winner
//   valid : at least one request present
//   idx   : first set request scanning from last+1 (mod 4)
module rr_pick4
   import mem_arb_pkg::*;
(
   input  logic [NumReq-1:0] req,
   input  logic [1:0]        last,
   output logic              valid,
   output logic [1:0]        idx
);

   // Scan from the lowest-priority offset (last itself) up to last+1 so the
   // final hit, i.e. the highest-priority one, is what remains in idx.
   always_comb begin
      logic [1:0] j;
      valid = 1'b0;
      idx   = 2'd0;
      j     = 2'd0;
      for (int i = 4; i >= 1; i--) begin
         j = last + 2'(i);
         if (req[j]) begin
            valid = 1'b1;
            idx   = j;
         end
      end
   end

endmodule

// File: rtl/mem_req_arb.sv
// Round-robin arbiter granting four requesters access to one memory controller.
// After each accept (or watchdog expiry) a recovery window of RECOV_CYC cycles
// lets the controller write back before the next grant.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : mem_req_arb_if.slave (req/gnt/ack, do_rdy/do_acpt, memsel,
//               busy/err, power sequencing)
// Optional power sequencing (PSAVE/POFF/PREST) is built when the macro
// MEM_REQ_ARB_PWR_EN is defined; otherwise the power inputs are ignored and
// mc_pwr stays 1.
module mem_req_arb
   import mem_arb_pkg::*;
#(
   parameter int unsigned RECOV_CYC = 7,
   parameter int unsigned WDOG_CYC  = 16
) (
   input  logic           clk,
   input  logic           rstn,
   mem_req_arb_if.slave   bus
);

   localparam int unsigned CntMax = (RECOV_CYC > WDOG_CYC) ? RECOV_CYC : WDOG_CYC;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   state_e            state_q, state_d;
   logic [NumReq-1:0] gnt_q, gnt_d;
   logic [NumReq-1:0] ack_q, ack_d;
   logic [1:0]        memsel_q, memsel_d;
   logic [1:0]        last_q, last_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              do_rdy_q, do_rdy_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              mc_pwr_q, mc_pwr_d;
   logic              mc_save_q, mc_save_d;
   logic              mc_restore_q, mc_restore_d;

   logic              pick_valid;
   logic [1:0]        pick_idx;
   logic              pwr_dn;

   rr_pick4 u_pick (
      .req   (bus.req),
      .last  (last_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

`ifdef MEM_REQ_ARB_PWR_EN
   assign pwr_dn = bus.pwr_dn_req;
`else
   assign pwr_dn = 1'b0;
   logic unused_pwr;
   assign unused_pwr = ^{bus.pwr_dn_req, bus.pwr_up_req, bus.mc_pwr_ack};
`endif

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      ack_d        = '0;
      memsel_d     = memsel_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      do_rdy_d     = do_rdy_q;
      err_d        = 1'b0;
      mc_pwr_d     = mc_pwr_q;
      mc_save_d    = 1'b0;
      mc_restore_d = mc_restore_q;

      unique case (state_q)
         StIdle: begin
            // Power-down wins over a simultaneous request.
            if (pwr_dn) begin
               state_d   = StPsave;
               mc_save_d = 1'b1;
            end else if (pick_valid) begin
               state_d  = StGrant;
               gnt_d    = onehot4(pick_idx);
               memsel_d = pick_idx;
               do_rdy_d = 1'b1;
               cnt_d    = '0;
            end
         end
         StGrant: begin
            // memsel_q holds the winner for the whole grant.
            if (bus.do_acpt) begin
               state_d  = StRecov;
               ack_d    = onehot4(memsel_q);
               gnt_d    = '0;
               do_rdy_d = 1'b0;
               last_d   = memsel_q;
               cnt_d    = CntW'(RECOV_CYC - 1);
            end else if (cnt_q == CntW'(WDOG_CYC - 1)) begin
               state_d  = StRecov;
               err_d    = 1'b1;
               gnt_d    = '0;
               do_rdy_d = 1'b0;
               cnt_d    = CntW'(RECOV_CYC - 1);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRecov: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef MEM_REQ_ARB_PWR_EN
         StPsave: begin
            state_d  = StPoff;
            mc_pwr_d = 1'b0;
         end
         StPoff: begin
            if (bus.pwr_up_req) begin
               state_d      = StPrest;
               mc_pwr_d     = 1'b1;
               mc_restore_d = 1'b1;
            end
         end
         StPrest: begin
            if (bus.mc_pwr_ack) begin
               state_d      = StIdle;
               mc_restore_d = 1'b0;
            end
         end
`endif
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= StIdle;
         gnt_q        <= '0;
         ack_q        <= '0;
         memsel_q     <= 2'd0;
         last_q       <= 2'd3;
         cnt_q        <= '0;
         do_rdy_q     <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         mc_pwr_q     <= 1'b1;
         mc_save_q    <= 1'b0;
         mc_restore_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         ack_q        <= ack_d;
         memsel_q     <= memsel_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         do_rdy_q     <= do_rdy_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         mc_pwr_q     <= mc_pwr_d;
         mc_save_q    <= mc_save_d;
         mc_restore_q <= mc_restore_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.ack        = ack_q;
   assign bus.memsel     = memsel_q;
   assign bus.do_rdy     = do_rdy_q;
   assign bus.busy       = busy_q;
   assign bus.err        = err_q;
   assign bus.mc_pwr     = mc_pwr_q;
   assign bus.mc_save    = mc_save_q;
   assign bus.mc_restore = mc_restore_q;

endmodule

// File: tb/tb_mem_req_arb.sv
// Self-checking bench for mem_req_arb: directed scenarios followed by random
// transactions, checked against a transaction-level round-robin model.
module tb_mem_req_arb;

   localparam int Recov = 7;
   localparam int Wdog  = 16;

   logic clk;
   logic rstn;
   int   n_tests;
   int   n_fail;
   int   last_m;

   mem_req_arb_if bus_if ();

   mem_req_arb #(
      .RECOV_CYC (Recov),
      .WDOG_CYC  (Wdog)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1, "bench time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: scan from last+1 upward (mod 4), first set bit wins.
   function automatic int ref_pick(input logic [3:0] r, input int last);
      for (int i = 1; i <= 4; i++) begin
         int j;
         j = (last + i) % 4;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      chk("rst_busy", bus_if.busy, 0);
      chk("rst_gnt", bus_if.gnt, 0);
      chk("rst_ack", bus_if.ack, 0);
      chk("rst_do_rdy", bus_if.do_rdy, 0);
      chk("rst_memsel", bus_if.memsel, 0);
      chk("rst_err", bus_if.err, 0);
      chk("rst_mc_pwr", bus_if.mc_pwr, 1);
      chk("rst_mc_save", bus_if.mc_save, 0);
      chk("rst_mc_restore", bus_if.mc_restore, 0);
      rstn   = 1'b1;
      last_m = 3;
   endtask

   // Precondition: arbiter observed idle. Runs one grant, either accepted after
   // dly GRANT cycles or left to the watchdog, then the full recovery window.
   task automatic do_txn(input logic [3:0] r, input int dly, input bit tmo, input bit pdn);
      int         w;
      logic [3:0] oh;
      w  = ref_pick(r, last_m);
      oh = 4'b0001 << w;
      bus_if.req        = r;
      bus_if.pwr_dn_req = pdn;
      tick();
      bus_if.pwr_dn_req = 1'b0;
      chk("grant_do_rdy", bus_if.do_rdy, 1);
      chk("grant_gnt", bus_if.gnt, oh);
      chk("grant_memsel", bus_if.memsel, w);
      chk("grant_busy", bus_if.busy, 1);
      chk("grant_mc_pwr", bus_if.mc_pwr, 1);
      chk("grant_mc_save", bus_if.mc_save, 0);
      if (tmo) begin
         for (int i = 1; i < Wdog; i++) begin
            bus_if.req = 4'($urandom);
            tick();
            chk("wdog_hold_rdy", bus_if.do_rdy, 1);
            chk("wdog_hold_gnt", bus_if.gnt, oh);
            chk("wdog_no_err", bus_if.err, 0);
         end
         tick();
         chk("wdog_err", bus_if.err, 1);
         chk("wdog_rdy_clr", bus_if.do_rdy, 0);
         chk("wdog_gnt_clr", bus_if.gnt, 0);
         chk("wdog_no_ack", bus_if.ack, 0);
      end else begin
         for (int i = 0; i < dly; i++) begin
            bus_if.req = 4'($urandom);
            tick();
            chk("hold_rdy", bus_if.do_rdy, 1);
            chk("hold_gnt", bus_if.gnt, oh);
            chk("hold_memsel", bus_if.memsel, w);
            chk("hold_no_ack", bus_if.ack, 0);
         end
         bus_if.do_acpt = 1'b1;
         tick();
         bus_if.do_acpt = 1'b0;
         chk("acpt_ack", bus_if.ack, oh);
         chk("acpt_rdy_clr", bus_if.do_rdy, 0);
         chk("acpt_gnt_clr", bus_if.gnt, 0);
         chk("acpt_no_err", bus_if.err, 0);
         last_m = w;
      end
      for (int i = 1; i < Recov; i++) begin
         bus_if.req     = 4'($urandom);
         bus_if.do_acpt = 1'($urandom_range(0, 1));
         tick();
         chk("recov_busy", bus_if.busy, 1);
         chk("recov_no_rdy", bus_if.do_rdy, 0);
         chk("recov_no_ack", bus_if.ack, 0);
         chk("recov_no_err", bus_if.err, 0);
      end
      bus_if.do_acpt = 1'b0;
      tick();
      chk("idle_busy", bus_if.busy, 0);
      chk("idle_no_rdy", bus_if.do_rdy, 0);
   endtask

   initial begin
      n_tests           = 0;
      n_fail            = 0;
      last_m            = 3;
      rstn              = 1'b0;
      bus_if.req        = '0;
      bus_if.do_acpt    = 1'b0;
      bus_if.pwr_dn_req = 1'b0;
      bus_if.pwr_up_req = 1'b0;
      bus_if.mc_pwr_ack = 1'b0;

      // Alternating pair with accept three cycles into each grant.
      do_reset();
      for (int k = 0; k < 4; k++) do_txn(4'b0101, 3, 1'b0, 1'b0);

      // All requesting: 0,1,2,3,0.
      do_reset();
      for (int k = 0; k < 5; k++) do_txn(4'b1111, 1, 1'b0, 1'b0);

      // Watchdog leaves last winner alone: 1 wins again from 4'b1010.
      do_reset();
      do_txn(4'b0010, 0, 1'b1, 1'b0);
      do_txn(4'b1010, 0, 1'b0, 1'b0);

      // Reset in the middle of a grant.
      bus_if.req = 4'b0100;
      tick();
      chk("pre_rst_do_rdy", bus_if.do_rdy, 1);
      do_reset();
      do_txn(4'b1100, 2, 1'b0, 1'b0);

`ifdef MEM_REQ_ARB_PWR_EN
      do_reset();
      bus_if.req        = 4'b0001;
      bus_if.pwr_dn_req = 1'b1;
      tick();
      bus_if.pwr_dn_req = 1'b0;
      chk("psave_mc_save", bus_if.mc_save, 1);
      chk("psave_no_rdy", bus_if.do_rdy, 0);
      chk("psave_busy", bus_if.busy, 1);
      tick();
      chk("poff_mc_save_clr", bus_if.mc_save, 0);
      for (int i = 0; i < 3; i++) begin
         chk("poff_mc_pwr", bus_if.mc_pwr, 0);
         chk("poff_no_rdy", bus_if.do_rdy, 0);
         tick();
      end
      bus_if.pwr_up_req = 1'b1;
      tick();
      bus_if.pwr_up_req = 1'b0;
      chk("prest_mc_pwr", bus_if.mc_pwr, 1);
      chk("prest_restore", bus_if.mc_restore, 1);
      chk("prest_no_rdy", bus_if.do_rdy, 0);
      bus_if.mc_pwr_ack = 1'b1;
      tick();
      bus_if.mc_pwr_ack = 1'b0;
      chk("prest_restore_clr", bus_if.mc_restore, 0);
      chk("prest_idle", bus_if.busy, 0);
      do_txn(4'b0001, 1, 1'b0, 1'b0);
`else
      do_reset();
      do_txn(4'b0001, 1, 1'b0, 1'b1);
      chk("nopwr_mc_pwr", bus_if.mc_pwr, 1);
      chk("nopwr_mc_restore", bus_if.mc_restore, 0);
`endif

      // Random transactions against the model.
      do_reset();
      for (int k = 0; k < 24; k++) begin
         logic [3:0] r;
         int         dly;
         bit         tmo;
         r   = 4'($urandom_range(1, 15));
         dly = $urandom_range(0, 6);
         tmo = ($urandom_range(0, 7) == 0);
         do_txn(r, dly, tmo, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_req_arb.md
MEM_REQ_ARB -- requirements
Module: mem_req_arb

Interface
REQ-001 SHALL have parameter RECOV_CYC, default 7: idle cycles after do_acpt before the next do_rdy, covering controller write-back and return to S0.
REQ-002 SHALL have parameter WDOG_CYC, default 16: maximum cycles in GRANT waiting for do_acpt.
REQ-003 SHALL use one clock; reset is synchronous and active-low: clk input 1, rising-edge clock; rstn input 1, synchronous active-low reset.
REQ-004 SHALL have ports, each: name, direction, width, meaning.
- req  input  4  requester i wants one memory transaction.
- gnt  output  4  one-hot, the granted requester.
- ack  output  4  one-cycle pulse to the requester whose transaction was accepted.
- do_rdy  output  1  request to the controller.
- memsel  output  2  bank select, equal to the granted index.
- do_acpt  input  1  controller accept pulse.
- busy  output  1  high in any state except IDLE.
- err  output  1  one-cycle watchdog pulse.
- pwr_dn_req  input  1  power-down request.
- pwr_up_req  input  1  power-up request.
- mc_pwr  output  1  controller power enable.
- mc_save  output  1  state-save strobe.
- mc_restore  output  1  state-restore strobe.
- mc_pwr_ack  input  1  power sequencing acknowledge.

Function
REQ-005 SHALL register all outputs; no combinational path from input to output.
REQ-006 SHALL implement the FSM states IDLE, GRANT, RECOV, PSAVE, POFF and PREST.
REQ-007 SHALL arbitrate round-robin: in IDLE with req nonzero, search starts at index last_winner+1 mod 4; the first set bit wins.
REQ-008 SHALL, in the cycle after a winner is chosen, enter GRANT with gnt one-hot, memsel equal to the winner index, and do_rdy=1.
REQ-009 SHALL, in GRANT, hold gnt, memsel and do_rdy stable regardless of req changes; deasserting req SHALL NOT cancel the grant.
REQ-010 SHALL, on do_acpt=1 in GRANT, on the next cycle: pulse ack[winner] for one cycle, clear do_rdy and gnt, update last_winner, and enter RECOV with the counter loaded to RECOV_CYC-1.
REQ-011 SHALL decrement the counter each cycle in RECOV and enter IDLE when it reaches 0; RECOV SHALL last exactly RECOV_CYC cycles.
REQ-012 SHALL ignore do_acpt outside GRANT.
REQ-013 SHALL count cycles in GRANT; if WDOG_CYC cycles pass without do_acpt, SHALL pulse err for one cycle, clear do_rdy and gnt, leave last_winner unchanged, and enter RECOV.
REQ-014 SHALL give minimum request-to-request spacing of one arbitration cycle plus GRANT time plus RECOV_CYC.
REQ-015 SHALL, when pwr_dn_req and req are both set in IDLE, serve the power request first; pwr_dn_req SHALL NOT be sampled outside IDLE.

Reset
REQ-016 SHALL, with rstn=0 at a clk edge, regardless of state (including mid-GRANT), reset to: state IDLE, gnt=0, ack=0, do_rdy=0, memsel=0, busy=0, err=0, mc_pwr=1, mc_save=0, mc_restore=0, last_winner=3, counters=0.
REQ-017 SHALL, because last_winner resets to 3, give the first grant after reset to the lowest set req index.

Configuration
REQ-018 SHALL include power sequencing when MEM_REQ_ARB_PWR_EN is defined.
- IDLE to PSAVE on pwr_dn_req; mc_save pulses 1 cycle.
- PSAVE to POFF; mc_pwr=0 held.
- POFF to PREST on pwr_up_req; mc_pwr=1, mc_restore=1.
- PREST to IDLE on mc_pwr_ack=1; mc_restore clears on exit.
- req is not granted in PSAVE, POFF or PREST.
REQ-019 SHALL, without MEM_REQ_ARB_PWR_EN:
- keep all ports present;
- tie mc_pwr=1, mc_save=0, mc_restore=0;
- ignore pwr_dn_req, pwr_up_req and mc_pwr_ack;
- make PSAVE, POFF and PREST unreachable.

Structure
REQ-020 SHALL place the state encoding localparams (4-bit, IDLE=0) and the requester count constant 4 in shared package mem_arb_pkg.
REQ-021 SHALL implement round-robin selection as sub-module rr_pick4: inputs req[3:0] and last[1:0]; outputs valid and idx[1:0]; purely combinational.

Verification
REQ-022 SHALL cover: reset, then req=4'b0101 held, do_acpt returned 3 cycles after do_rdy -> grants alternate 0,2,0,2; ack[0] and ack[2] pulse once per grant; do_rdy gaps are at least 7 cycles.
REQ-023 SHALL cover: req=4'b1111 -> grant order 0,1,2,3,0; memsel tracks the grant index.
REQ-024 SHALL cover: do_acpt never asserted with req=4'b0010 -> err pulses 16 cycles after do_rdy rises; the next grant goes to index 1 again.
REQ-025 SHALL cover: rstn=0 for 1 cycle during GRANT -> the next cycle shows do_rdy=0, gnt=0, busy=0, mc_pwr=1.
REQ-026 SHALL cover, with MEM_REQ_ARB_PWR_EN: pwr_dn_req and req=4'b0001 together in IDLE -> mc_save pulses, mc_pwr=0, no do_rdy; then pwr_up_req and mc_pwr_ack -> mc_restore clears, IDLE is reached, and req 0 is granted.
REQ-027 SHALL cover, without the macro: pwr_dn_req pulsed -> mc_pwr stays 1; arbitration is unaffected.
